sa_rr_packet_arbiter_3port: RTL and testbench
=============================================

// Module: sa_rr_packet_arbiter_3port
// PURPOSE
//   Switch-allocation controller for the 3-port border router (X, Y, LOCAL).
//   Shares each output port among the three input FIFOs with per-output round-robin
//   and holds a grant across multi-flit packets (wormhole lock).
//   Sits between the route-compute stage (per-input destination) and the output crossbar.
//   Drives crossbar selects, per-input pop grants and per-output valid.
// PARAMETERS
//   LOCK_MAX  16  max flits per locked packet before forced release; range 2..255
//   CNT_W      8  width of per-output flit counter; must hold LOCK_MAX
// PORTS
//   clk          in   1  rising-edge clock
//   rst          in   1  synchronous, active-high reset
//   req_valid_i  in   3  per input [0]=X [1]=Y [2]=LOCAL: head-of-FIFO flit valid
//   req_dst_i    in   6  2b/input {L,Y,X}: 0=X out, 1=Y out, 2=LOCAL out, 3=invalid
//   req_last_i   in   3  per input: current flit is last of packet (single flit: last=1)
//   out_full_i   in   3  per output: downstream full; LOCAL instance ties [2]=0
//   gnt_o        out  3  per input: flit transferred this cycle (pop FIFO); comb.
//   out_sel_o    out  6  2b/output: source input index, 2'b11 = none; comb.
//   out_valid_o  out  3  per output: flit crosses switch this cycle; comb.
//   lock_o       out  3  per output: packet lock held (registered state)
//   err_o        out  3  per output sticky: LOCK_MAX forced release occurred
// BEHAVIOUR
//   State per output o: st[o] in {IDLE, LOCKED}, owner[o] 2b, ptr[o] 2b (0..2), cnt[o] CNT_W.
//   Reset (rst=1 at edge): st=IDLE, owner=0, ptr=0, cnt=0, err_o=0; comb outputs then
//     gnt_o=0, out_valid_o=0, out_sel_o=6'h3F, lock_o=0. Mid-packet reset drops all locks.
//   Candidates(o) = {i : req_valid_i[i] & req_dst_i[i]==o}; dst==3 never granted.
//   Transfer on o in a cycle iff out_full_i[o]=0 and a winner exists; then
//     gnt_o[winner]=1, out_sel_o[o]=winner, out_valid_o[o]=1; else sel=3, valid=0.
//   Latency 0: grant is combinational from registered state + current requests;
//     state updates at the same clock edge as the transfer.
//   IDLE: winner = first candidate scanning ptr[o], ptr[o]+1, ptr[o]+2 (mod 3).
//     On transfer: ptr[o] <= (winner+1) mod 3;
//     last=0 -> st=LOCKED, owner=winner, cnt=1; last=1 -> stay IDLE.
//   LOCKED: only owner[o] may win (owner must be a candidate); others ignored.
//     On transfer: cnt<=cnt+1; last=1 -> IDLE, cnt=0.
//     If cnt+1==LOCK_MAX and last=0 -> forced IDLE, cnt=0, err_o[o] set (sticky till rst).
//     No transfer (owner not valid, dst mismatch or out_full): lock and cnt held, ptr unchanged.
//   Release cycle: the last flit is the only grant on o; new arbitration starts next cycle.
//   out_full_i[o]=1: no grant on o in either state; ptr/state unchanged.
//   Each input requests one output, so gnt_o has at most one grant per input per cycle.
//   Several outputs may transfer in the same cycle from distinct inputs.
//   ptr advances only on a head-flit grant in IDLE, never on a body flit.
// TESTING
//   1) Reset: rst=1 with all reqs high -> gnt_o=0, out_sel_o=6'h3F, lock_o=0, err_o=0.
//      Release rst -> first grant goes to input 0 (ptr=0).
//   2) RR fairness: inputs 0,1,2 each send continuous single-flit pkts to Y, 9 cycles
//      -> gnt order 0,1,2,0,1,2,0,1,2; out_valid_o[1]=1 every cycle.
//   3) Lock: input 1 sends 4-flit pkt to X while input 2 also requests X
//      -> gnt_o[1] 4 consecutive cycles, lock_o[0]=1 for 3 cycles, then input 2 granted.
//   4) Backpressure: mid-pkt set out_full_i[0]=1 for 3 cycles -> no gnt on X, lock held,
//      cnt frozen; resumes with the owner's next flit when full drops.
//   5) Watchdog: LOCK_MAX=4, input 0 streams last=0 to LOCAL -> release after 4th flit,
//      err_o[2]=1 and stays 1; the next requester is then arbitrated normally.
//   6) Parallel/invalid: X->Y, Y->X, L->L same cycle -> gnt_o=3'b111, out_valid_o=3'b111;
//      dst=3 -> never granted.

Source files
------------

// File: rtl/sa_rr_packet_arbiter_3port.sv
// sa_rr_packet_arbiter_3port: per-output round-robin switch allocator with wormhole lock
module sa_rr_packet_arbiter_3port #(
  parameter int LOCK_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req_valid_i,
  input  logic [5:0] req_dst_i,
  input  logic [2:0] req_last_i,
  input  logic [2:0] out_full_i,
  output logic [2:0] gnt_o,
  output logic [5:0] out_sel_o,
  output logic [2:0] out_valid_o,
  output logic [2:0] lock_o,
  output logic [2:0] err_o
);
  typedef enum logic {IDLE, LOCKED} st_t;
  logic [2:0] w_gv [3];
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_out
    st_t              r_st, w_st;
    logic [1:0]       r_owner, w_owner, r_ptr, w_ptr, w_win, w_idx;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_err, w_err, w_has, w_xfer;
    logic [2:0]       w_cand;
    always_comb
      for (int i = 0; i < 3; i++) w_cand[i] = req_valid_i[i] && (req_dst_i[2*i+:2] == 2'(g));
    // While locked only the owner can win; otherwise scan from the RR pointer
    always_comb begin
      w_has   = 1'b0;
      w_win   = r_owner;
      w_idx   = r_ptr;
      if (r_st == LOCKED) w_has = w_cand[r_owner];
      else
        for (int k = 0; k < 3; k++) begin
          if (!w_has && w_cand[w_idx]) begin
            w_has = 1'b1;
            w_win = w_idx;
          end
          w_idx = nxt(w_idx);
        end
      w_xfer  = w_has && !out_full_i[g] && !rst;
      w_st    = r_st;
      w_owner = r_owner;
      w_ptr   = r_ptr;
      w_cnt   = r_cnt;
      w_err   = r_err;
      if (w_xfer && r_st == IDLE) begin
        w_ptr = nxt(w_win);
        if (!req_last_i[w_win]) begin
          w_st    = LOCKED;
          w_owner = w_win;
          w_cnt   = CNT_W'(1);
        end
      end else if (w_xfer) begin
        w_cnt = r_cnt + CNT_W'(1);
        if (req_last_i[w_win] || w_cnt == CNT_W'(LOCK_MAX)) begin
          w_st  = IDLE;
          w_cnt = '0;
          w_err = r_err | !req_last_i[w_win];
        end
      end
    end
    always_ff @(posedge clk)
      if (rst) begin
        r_st    <= IDLE;
        r_owner <= '0;
        r_ptr   <= '0;
        r_cnt   <= '0;
        r_err   <= 1'b0;
      end else begin
        r_st    <= w_st;
        r_owner <= w_owner;
        r_ptr   <= w_ptr;
        r_cnt   <= w_cnt;
        r_err   <= w_err;
      end
    assign out_sel_o[2*g+:2] = w_xfer ? w_win : 2'b11;
    assign out_valid_o[g]    = w_xfer;
    assign lock_o[g]         = (r_st == LOCKED);
    assign err_o[g]          = r_err;
    assign w_gv[g]           = w_xfer ? 3'(3'b001 << w_win) : 3'b000;
  end
  assign gnt_o = w_gv[0] | w_gv[1] | w_gv[2];
endmodule

// File: tb/tb_sa_rr_packet_arbiter_3port.sv
// tb_sa_rr_packet_arbiter_3port: scenario tasks with a per-cycle expected-value scoreboard
module tb_sa_rr_packet_arbiter_3port;
  logic       clk = 1'b0, rst = 1'b1;
  logic [2:0] req_valid = '0, req_last = '0, out_full = '0;
  logic [5:0] req_dst = '0;
  logic [2:0] gnt_o, out_valid_o, lock_o, err_o;
  logic [5:0] out_sel_o;
  logic [17:0] sb[$];
  int n_cmp = 0, n_bad = 0;

  sa_rr_packet_arbiter_3port #(.LOCK_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_dst_i(req_dst),
    .req_last_i(req_last), .out_full_i(out_full), .gnt_o(gnt_o),
    .out_sel_o(out_sel_o), .out_valid_o(out_valid_o), .lock_o(lock_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    {req_valid, req_dst, req_last, out_full} = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] s[5];
    logic [17:0] e[5];
    logic        r[5];
    logic [17:0] want, obs;
    r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) s[k] = {3'b111, 6'b000000, 3'b111, 3'b000};
    e = '{{3'b000, 6'b111111, 3'b000, 3'b000, 3'b000},
          {3'b000, 6'b111111, 3'b000, 3'b000, 3'b000},
          {3'b001, 6'b111100, 3'b001, 3'b000, 3'b000},
          {3'b010, 6'b111101, 3'b001, 3'b000, 3'b000},
          {3'b100, 6'b111110, 3'b001, 3'b000, 3'b000}};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rst = r[k];
      {req_valid, req_dst, req_last, out_full} = s[k];
      sb.push_back(e[k]);
      #1;
      want = sb.pop_front();
      obs = {gnt_o, out_sel_o, out_valid_o, lock_o, err_o};
      n_cmp++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL reset[%0d] gnt/sel/vld/lock/err got %b want %b", k, obs, want);
      end
    end
  endtask

  task automatic test_rr_fairness();
    logic [17:0] want, obs;
    logic [1:0]  w;
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      w = 2'(k % 3);
      @(negedge clk);
      {req_valid, req_dst, req_last, out_full} = {3'b111, 6'b010101, 3'b111, 3'b000};
      sb.push_back({3'(3'b001 << w), 2'b11, w, 2'b11, 3'b010, 3'b000, 3'b000});
      #1;
      want = sb.pop_front();
      obs = {gnt_o, out_sel_o, out_valid_o, lock_o, err_o};
      n_cmp++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL rr[%0d] gnt/sel/vld/lock/err got %b want %b", k, obs, want);
      end
    end
  endtask

  task automatic test_lock();
    logic [14:0] s[5];
    logic [17:0] e[5];
    logic [17:0] want, obs;
    s = '{{3'b110, 6'b000000, 3'b100, 3'b000},
          {3'b110, 6'b000000, 3'b100, 3'b000},
          {3'b110, 6'b000000, 3'b100, 3'b000},
          {3'b110, 6'b000000, 3'b110, 3'b000},
          {3'b100, 6'b000000, 3'b100, 3'b000}};
    e = '{{3'b010, 6'b111101, 3'b001, 3'b000, 3'b000},
          {3'b010, 6'b111101, 3'b001, 3'b001, 3'b000},
          {3'b010, 6'b111101, 3'b001, 3'b001, 3'b000},
          {3'b010, 6'b111101, 3'b001, 3'b001, 3'b000},
          {3'b100, 6'b111110, 3'b001, 3'b000, 3'b000}};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      {req_valid, req_dst, req_last, out_full} = s[k];
      sb.push_back(e[k]);
      #1;
      want = sb.pop_front();
      obs = {gnt_o, out_sel_o, out_valid_o, lock_o, err_o};
      n_cmp++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL lock[%0d] gnt/sel/vld/lock/err got %b want %b", k, obs, want);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [14:0] s[8];
    logic [17:0] e[8];
    logic [17:0] want, obs;
    s = '{{3'b001, 6'b000000, 3'b000, 3'b000},
          {3'b101, 6'b000000, 3'b100, 3'b001},
          {3'b101, 6'b000000, 3'b100, 3'b001},
          {3'b101, 6'b000000, 3'b100, 3'b001},
          {3'b101, 6'b000000, 3'b100, 3'b000},
          {3'b101, 6'b000000, 3'b100, 3'b000},
          {3'b101, 6'b000000, 3'b101, 3'b000},
          {3'b100, 6'b000000, 3'b100, 3'b000}};
    e = '{{3'b001, 6'b111100, 3'b001, 3'b000, 3'b000},
          {3'b000, 6'b111111, 3'b000, 3'b001, 3'b000},
          {3'b000, 6'b111111, 3'b000, 3'b001, 3'b000},
          {3'b000, 6'b111111, 3'b000, 3'b001, 3'b000},
          {3'b001, 6'b111100, 3'b001, 3'b001, 3'b000},
          {3'b001, 6'b111100, 3'b001, 3'b001, 3'b000},
          {3'b001, 6'b111100, 3'b001, 3'b001, 3'b000},
          {3'b100, 6'b111110, 3'b001, 3'b000, 3'b000}};
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      {req_valid, req_dst, req_last, out_full} = s[k];
      sb.push_back(e[k]);
      #1;
      want = sb.pop_front();
      obs = {gnt_o, out_sel_o, out_valid_o, lock_o, err_o};
      n_cmp++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL backpressure[%0d] gnt/sel/vld/lock/err got %b want %b", k, obs, want);
      end
    end
  endtask

  task automatic test_watchdog();
    logic [14:0] s[6];
    logic [17:0] e[6];
    logic [17:0] want, obs;
    s = '{{3'b001, 6'b001010, 3'b000, 3'b000},
          {3'b011, 6'b001010, 3'b010, 3'b000},
          {3'b011, 6'b001010, 3'b010, 3'b000},
          {3'b011, 6'b001010, 3'b010, 3'b000},
          {3'b011, 6'b001010, 3'b010, 3'b000},
          {3'b001, 6'b001010, 3'b000, 3'b000}};
    e = '{{3'b001, 6'b001111, 3'b100, 3'b000, 3'b000},
          {3'b001, 6'b001111, 3'b100, 3'b100, 3'b000},
          {3'b001, 6'b001111, 3'b100, 3'b100, 3'b000},
          {3'b001, 6'b001111, 3'b100, 3'b100, 3'b000},
          {3'b010, 6'b011111, 3'b100, 3'b000, 3'b100},
          {3'b001, 6'b001111, 3'b100, 3'b000, 3'b100}};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      {req_valid, req_dst, req_last, out_full} = s[k];
      sb.push_back(e[k]);
      #1;
      want = sb.pop_front();
      obs = {gnt_o, out_sel_o, out_valid_o, lock_o, err_o};
      n_cmp++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL watchdog[%0d] gnt/sel/vld/lock/err got %b want %b", k, obs, want);
      end
    end
  endtask

  task automatic test_parallel_invalid();
    logic [14:0] s[3];
    logic [17:0] e[3];
    logic [17:0] want, obs;
    s = '{{3'b111, 6'b100001, 3'b111, 3'b000},
          {3'b111, 6'b111111, 3'b111, 3'b000},
          {3'b111, 6'b110111, 3'b111, 3'b000}};
    e = '{{3'b111, 6'b100001, 3'b111, 3'b000, 3'b000},
          {3'b000, 6'b111111, 3'b000, 3'b000, 3'b000},
          {3'b010, 6'b110111, 3'b010, 3'b000, 3'b000}};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      {req_valid, req_dst, req_last, out_full} = s[k];
      sb.push_back(e[k]);
      #1;
      want = sb.pop_front();
      obs = {gnt_o, out_sel_o, out_valid_o, lock_o, err_o};
      n_cmp++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL parallel[%0d] gnt/sel/vld/lock/err got %b want %b", k, obs, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_lock();
    test_backpressure();
    test_watchdog();
    test_parallel_invalid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
